ifmap_input_controller: RTL and testbench
=========================================

# ifmap_input_controller

Upstream feeder for the ifmap double buffer. It accepts the ifmap stream through a valid/ready handshake and writes each tile into the current write bank. It tells the main FSM when a bank is full and ready to be swapped, and when every tile of the layer has been written. It swaps banks on the FSM's switch strobe and starts the next fill only on the FSM's start strobe.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one ifmap word
- BANK_ADDR_WIDTH, 10, write-address width of one bank
- COUNT_WIDTH, 16, width of the tile (bank) counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- config_en  in  1  one-cycle strobe; latches bank_depth and num_banks
- bank_depth  in  BANK_ADDR_WIDTH+1  words per tile, valid range 1..2^BANK_ADDR_WIDTH
- num_banks  in  COUNT_WIDTH  tiles per layer, i.e. oy1*ox1, valid range ≥1
- ifmap_data  in  DATA_WIDTH  stream data
- ifmap_valid  in  1  stream valid
- ifmap_ready  out  1  stream ready
- ifmap_wen  out  1  buffer write enable
- ifmap_waddr  out  BANK_ADDR_WIDTH  buffer write address within the write bank
- ifmap_wdata  out  DATA_WIDTH  buffer write data
- ifmap_write_bank_sel  out  1  index of the bank currently being written; the read bank is its inverse
- ifmap_ready_to_switch  in  1  FSM strobe: swap banks
- ifmap_start_new_write_bank  in  1  FSM strobe: begin filling the new write bank
- ifmap_write_bank_ready_to_switch  out  1  write bank is full
- all_ifmap_write_bank_done  out  1  all num_banks tiles have been written
- banks_filled  out  COUNT_WIDTH  number of tiles completely written so far

## Operation
States:
- IDLE: waiting for configuration.
  - config_en with bank_depth≠0 and num_banks≠0 latches both values → FILL.
  - config_en with a zero in either value is ignored; the block stays in IDLE.
- FILL:
  - ifmap_ready=1.
  - Each beat with ifmap_valid&ifmap_ready writes ifmap_data at addr, then addr increments.
  - The beat at addr==bank_depth-1 clears addr to 0, increments banks_filled, and moves to FULL.
- FULL:
  - ifmap_ready=0; ifmap_write_bank_ready_to_switch=1.
  - On ifmap_ready_to_switch, ifmap_write_bank_sel toggles. The next state is DONE if banks_filled==num_banks, otherwise WAIT_START.
- WAIT_START:
  - ifmap_ready=0.
  - ifmap_start_new_write_bank → FILL.
- DONE:
  - ifmap_ready=0; all_ifmap_write_bank_done stays 1.
  - config_en (valid values) clears banks_filled to 0, leaves ifmap_write_bank_sel unchanged, and moves to FILL for the next layer.

Rules:
- ifmap_wen = ifmap_valid & ifmap_ready. ifmap_waddr = addr. ifmap_wdata = ifmap_data. All three are combinational, so the write happens in the same cycle as the handshake.
- all_ifmap_write_bank_done = (banks_filled==num_banks) while in state FULL or DONE, and 0 otherwise. It is therefore valid in the same cycle as ifmap_ready_to_switch.
- Strobes are ignored outside their owning state:
  - ifmap_ready_to_switch only acts in FULL.
  - ifmap_start_new_write_bank only acts in WAIT_START.
  - config_en only acts in IDLE or DONE.
- ifmap_data is don't-care whenever ifmap_valid=0.
- Counter widths:
  - addr is BANK_ADDR_WIDTH+1 bits internally; only its low bits drive ifmap_waddr, and it never exceeds bank_depth-1.
  - banks_filled saturates at num_banks and never wraps.

## Timing
- Reset (synchronous): state=IDLE, addr=0, banks_filled=0, ifmap_write_bank_sel=0.
  - All outputs read 0: ifmap_ready, ifmap_wen, ifmap_write_bank_ready_to_switch, all_ifmap_write_bank_done.
  - rst asserted mid-fill drops the partial tile: no further writes, and the next tile starts at addr 0 after reconfiguration.
- Config: config_en in cycle t puts the block in FILL with ifmap_ready=1 in cycle t+1.
- Fill: one word per cycle at full throughput. The last beat lands in cycle t; in cycle t+1 ifmap_ready=0 and ifmap_write_bank_ready_to_switch=1.
- Switch: ifmap_ready_to_switch in cycle t gives, in cycle t+1, the toggled ifmap_write_bank_sel and ifmap_write_bank_ready_to_switch=0.
- Start: ifmap_start_new_write_bank in cycle t gives ifmap_ready=1 in cycle t+1.
- bank_depth=1: each accepted beat moves the block straight to FULL.
- The main FSM cannot assert ifmap_ready_to_switch and ifmap_start_new_write_bank in the same cycle. If a bench forces both, only the strobe belonging to the current state acts.

## Test plan
- Reset, then config D=4, N=2; stream 0xA0..0xA3 with valid held high → four writes at addr 0..3, bank_sel=0, ready_to_switch=1 in the cycle after 0xA3, banks_filled=1, all_done=0.
- After the first switch strobe → bank_sel=1, no writes until the start strobe. After start, stream 0xB0..0xB3 → full. At the second switch strobe all_done=1 in the same cycle → DONE, bank_sel=0.
- Valid toggling 1,0,1,0 during a fill → writes only on valid cycles, addresses stay contiguous, and ready_to_switch appears only after 4 accepted beats.
- Switch and start strobes pulsed during FILL, and config_en pulsed during FILL → no effect on bank_sel, addr or state.
- D=1, N=3 → three single-word tiles; each one reaches FULL one cycle after its beat; all_done=1 only when banks_filled=3.
- rst pulsed after 2 of 4 beats → all outputs 0 next cycle, bank_sel=0. Reconfigure and refill → the first write is at addr 0.

Source files
------------

// File: rtl/ifmap_input_controller.sv
// ============================================================================
// Module   : ifmap_input_controller
// Function : Writes the ifmap stream into the current bank of the double buffer
//            and handshakes bank swaps with the main FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifmap_input_controller #(
    parameter int DATA_WIDTH      = 16,
    parameter int BANK_ADDR_WIDTH = 10,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       config_en,
    input  logic [BANK_ADDR_WIDTH:0]   bank_depth,
    input  logic [COUNT_WIDTH-1:0]     num_banks,
    input  logic [DATA_WIDTH-1:0]      ifmap_data,
    input  logic                       ifmap_valid,
    output logic                       ifmap_ready,
    output logic                       ifmap_wen,
    output logic [BANK_ADDR_WIDTH-1:0] ifmap_waddr,
    output logic [DATA_WIDTH-1:0]      ifmap_wdata,
    output logic                       ifmap_write_bank_sel,
    input  logic                       ifmap_ready_to_switch,
    input  logic                       ifmap_start_new_write_bank,
    output logic                       ifmap_write_bank_ready_to_switch,
    output logic                       all_ifmap_write_bank_done,
    output logic [COUNT_WIDTH-1:0]     banks_filled
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_FULL       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [BANK_ADDR_WIDTH:0]   addr_q, addr_d;
    logic [BANK_ADDR_WIDTH:0]   depth_q, depth_d;
    logic [COUNT_WIDTH-1:0]     num_banks_q, num_banks_d;
    logic [COUNT_WIDTH-1:0]     banks_filled_q, banks_filled_d;
    logic                       bank_sel_q, bank_sel_d;

    logic w_cfg_ok;
    logic w_beat;
    logic w_last;
    logic w_all_filled;

    assign w_cfg_ok     = config_en && (bank_depth != '0) && (num_banks != '0);
    assign w_beat       = ifmap_valid && (state_q == ST_FILL);
    assign w_last       = (addr_q == depth_q - 1'b1);
    assign w_all_filled = (banks_filled_q == num_banks_q);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        depth_d        = depth_q;
        num_banks_d    = num_banks_q;
        banks_filled_d = banks_filled_q;
        bank_sel_d     = bank_sel_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new layer keeps the current bank polarity.
                if (w_cfg_ok) begin
                    depth_d        = bank_depth;
                    num_banks_d    = num_banks;
                    banks_filled_d = '0;
                    addr_d         = '0;
                    state_d        = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_beat) begin
                    if (w_last) begin
                        addr_d  = '0;
                        state_d = ST_FULL;
                        if (!w_all_filled) begin
                            banks_filled_d = banks_filled_q + 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (ifmap_ready_to_switch) begin
                    bank_sel_d = ~bank_sel_q;
                    state_d    = w_all_filled ? ST_DONE : ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (ifmap_start_new_write_bank) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            depth_q        <= '0;
            num_banks_q    <= '0;
            banks_filled_q <= '0;
            bank_sel_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            depth_q        <= depth_d;
            num_banks_q    <= num_banks_d;
            banks_filled_q <= banks_filled_d;
            bank_sel_q     <= bank_sel_d;
        end
    end

    assign ifmap_ready                      = (state_q == ST_FILL);
    assign ifmap_wen                        = ifmap_valid && ifmap_ready;
    assign ifmap_waddr                      = addr_q[BANK_ADDR_WIDTH-1:0];
    assign ifmap_wdata                      = ifmap_data;
    assign ifmap_write_bank_sel             = bank_sel_q;
    assign ifmap_write_bank_ready_to_switch = (state_q == ST_FULL);
    assign all_ifmap_write_bank_done        = ((state_q == ST_FULL) || (state_q == ST_DONE))
                                              && w_all_filled;
    assign banks_filled                     = banks_filled_q;

endmodule

`default_nettype wire

// File: tb/tb_ifmap_input_controller.sv
// ============================================================================
// Module   : tb_ifmap_input_controller
// Function : Directed and randomized checks of the ifmap input controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifmap_input_controller;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          config_en;
    logic [AW:0]   bank_depth;
    logic [CW-1:0] num_banks;
    logic [DW-1:0] ifmap_data;
    logic          ifmap_valid;
    logic          ifmap_ready;
    logic          ifmap_wen;
    logic [AW-1:0] ifmap_waddr;
    logic [DW-1:0] ifmap_wdata;
    logic          ifmap_write_bank_sel;
    logic          ifmap_ready_to_switch;
    logic          ifmap_start_new_write_bank;
    logic          ifmap_write_bank_ready_to_switch;
    logic          all_ifmap_write_bank_done;
    logic [CW-1:0] banks_filled;

    int   checks   = 0;
    int   failures = 0;
    logic exp_bank = 1'b0;

    ifmap_input_controller #(
        .DATA_WIDTH      (DW),
        .BANK_ADDR_WIDTH (AW),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk                              (clk),
        .rst                              (rst),
        .config_en                        (config_en),
        .bank_depth                       (bank_depth),
        .num_banks                        (num_banks),
        .ifmap_data                       (ifmap_data),
        .ifmap_valid                      (ifmap_valid),
        .ifmap_ready                      (ifmap_ready),
        .ifmap_wen                        (ifmap_wen),
        .ifmap_waddr                      (ifmap_waddr),
        .ifmap_wdata                      (ifmap_wdata),
        .ifmap_write_bank_sel             (ifmap_write_bank_sel),
        .ifmap_ready_to_switch            (ifmap_ready_to_switch),
        .ifmap_start_new_write_bank       (ifmap_start_new_write_bank),
        .ifmap_write_bank_ready_to_switch (ifmap_write_bank_ready_to_switch),
        .all_ifmap_write_bank_done        (all_ifmap_write_bank_done),
        .banks_filled                     (banks_filled)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, ifmap_ready, 0);
        check({tag, "_wen"}, ifmap_wen, 0);
        check({tag, "_rts"}, ifmap_write_bank_ready_to_switch, 0);
        check({tag, "_done"}, all_ifmap_write_bank_done, 0);
        check({tag, "_sel"}, ifmap_write_bank_sel, 0);
        check({tag, "_filled"}, banks_filled, 0);
    endtask

    task automatic configure(input int d, input int n);
        bank_depth  = (AW+1)'(d);
        num_banks   = CW'(n);
        config_en   = 1'b1;
        ifmap_valid = 1'b0;
        tick();
        config_en = 1'b0;
        #1;
        check("cfg_ready", ifmap_ready, 1);
        check("cfg_filled", banks_filled, 0);
        check("cfg_sel", ifmap_write_bank_sel, exp_bank);
        check("cfg_rts", ifmap_write_bank_ready_to_switch, 0);
        check("cfg_done", all_ifmap_write_bank_done, 0);
    endtask

    // mode 0: valid always high; 1: valid alternates 1,0; 2: random valid and data;
    // 3: valid always high with foreign strobes pulsed early in the tile.
    task automatic fill_tile(input int d, input int n, input int tile, input int mode,
                             input logic [DW-1:0] base);
        int            acc = 0;
        logic [DW-1:0] dat;
        for (int cyc = 0; cyc < 400 && acc < d; cyc++) begin
            case (mode)
                1:       ifmap_valid = (cyc % 2 == 0);
                2:       ifmap_valid = 1'($urandom_range(0, 1));
                default: ifmap_valid = 1'b1;
            endcase
            dat        = (mode == 2) ? DW'($urandom) : base + DW'(acc);
            ifmap_data = dat;
            if (mode == 3 && (cyc == 1 || cyc == 2)) begin
                ifmap_ready_to_switch      = 1'b1;
                ifmap_start_new_write_bank = 1'b1;
                config_en                  = 1'b1;
                bank_depth                 = (AW+1)'(7);
                num_banks                  = CW'(9);
            end
            #1;
            check("fill_ready", ifmap_ready, 1);
            check("fill_wen", ifmap_wen, ifmap_valid);
            if (ifmap_valid) begin
                check("fill_waddr", ifmap_waddr, acc);
                check("fill_wdata", ifmap_wdata, dat);
            end
            check("fill_sel", ifmap_write_bank_sel, exp_bank);
            check("fill_filled", banks_filled, tile);
            check("fill_rts", ifmap_write_bank_ready_to_switch, 0);
            check("fill_done", all_ifmap_write_bank_done, 0);
            if (ifmap_valid) acc++;
            tick();
            ifmap_ready_to_switch      = 1'b0;
            ifmap_start_new_write_bank = 1'b0;
            config_en                  = 1'b0;
        end
        check("fill_budget", acc, d);
        ifmap_valid = 1'b1;
        #1;
        check("full_ready", ifmap_ready, 0);
        check("full_wen", ifmap_wen, 0);
        check("full_rts", ifmap_write_bank_ready_to_switch, 1);
        check("full_filled", banks_filled, tile + 1);
        check("full_done", all_ifmap_write_bank_done, (tile + 1 == n));
    endtask

    task automatic switch_bank(input bit exp_done);
        int linger = int'($urandom_range(0, 2));
        for (int i = 0; i < linger; i++) begin
            ifmap_start_new_write_bank = 1'b1;
            tick();
            ifmap_start_new_write_bank = 1'b0;
            #1;
            check("linger_rts", ifmap_write_bank_ready_to_switch, 1);
            check("linger_ready", ifmap_ready, 0);
        end
        ifmap_ready_to_switch = 1'b1;
        ifmap_valid           = 1'b0;
        #1;
        check("switch_done_same", all_ifmap_write_bank_done, exp_done);
        tick();
        ifmap_ready_to_switch = 1'b0;
        exp_bank              = ~exp_bank;
        #1;
        check("switch_sel", ifmap_write_bank_sel, exp_bank);
        check("switch_rts", ifmap_write_bank_ready_to_switch, 0);
        check("switch_ready", ifmap_ready, 0);
        check("switch_done", all_ifmap_write_bank_done, exp_done);
        ifmap_valid = 1'b1;
        if (!exp_done) begin
            ifmap_ready_to_switch = 1'b1;
            tick();
            ifmap_ready_to_switch = 1'b0;
            #1;
            check("wait_ready", ifmap_ready, 0);
            check("wait_wen", ifmap_wen, 0);
            check("wait_sel", ifmap_write_bank_sel, exp_bank);
            ifmap_start_new_write_bank = 1'b1;
            tick();
            ifmap_start_new_write_bank = 1'b0;
            #1;
            check("start_ready", ifmap_ready, 1);
        end else begin
            tick();
            check("done_hold", all_ifmap_write_bank_done, 1);
            check("done_ready", ifmap_ready, 0);
            check("done_wen", ifmap_wen, 0);
        end
    endtask

    initial begin
        int d;
        int n;
        rst                        = 1'b1;
        config_en                  = 1'b0;
        bank_depth                 = '0;
        num_banks                  = '0;
        ifmap_data                 = '0;
        ifmap_valid                = 1'b1;
        ifmap_ready_to_switch      = 1'b0;
        ifmap_start_new_write_bank = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_quiet("reset");

        // Zero depth or zero tile count must leave the block idle.
        bank_depth = '0; num_banks = CW'(2); config_en = 1'b1;
        tick();
        bank_depth = (AW+1)'(4); num_banks = '0;
        tick();
        config_en = 1'b0;
        #1;
        check("badcfg_ready", ifmap_ready, 0);
        check("badcfg_wen", ifmap_wen, 0);

        configure(4, 2);
        fill_tile(4, 2, 0, 0, 16'h00A0);
        switch_bank(1'b0);
        fill_tile(4, 2, 1, 3, 16'h00B0);
        switch_bank(1'b1);

        configure(4, 2);
        fill_tile(4, 2, 0, 1, 16'h00C0);
        switch_bank(1'b0);
        fill_tile(4, 2, 1, 2, 16'h0000);
        switch_bank(1'b1);

        configure(1, 3);
        for (int t = 0; t < 3; t++) begin
            fill_tile(1, 3, t, 2, 16'h0000);
            switch_bank(t == 2);
        end

        repeat (3) begin
            d = int'($urandom_range(1, 8));
            n = int'($urandom_range(1, 4));
            configure(d, n);
            for (int t = 0; t < n; t++) begin
                fill_tile(d, n, t, 2, 16'h0000);
                switch_bank(t == n - 1);
            end
        end

        // Reset in the middle of a tile discards the partial fill.
        configure(4, 2);
        ifmap_valid = 1'b1;
        ifmap_data  = 16'h1111;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        exp_bank = 1'b0;
        #1;
        check_quiet("midrst");
        configure(4, 2);
        fill_tile(4, 2, 0, 0, 16'h00D0);
        switch_bank(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
